cache_ctrl: RTL and testbench

Controller for the direct-mapped, write-back data cache in the single-cycle MIPS core. It sits between the main control unit's memory strobes (load/store), the external cache data array, and the backing memory. It owns the tag, valid and dirty state and sequences write-back and refill on a miss. While a miss is serviced it stalls the core, holding the PC and suppressing the register write.

---
 rtl/cache_ctrl_pkg.sv | 29 ++
 rtl/cache_ctrl_if.sv | 37 +++
 rtl/cache_ctrl_tag_store.sv | 57 +++++
 rtl/cache_ctrl.sv | 134 +++++++++++++
 tb/tb_cache_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types, default widths and address field helpers for the data-cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int INDEX_W_DEF  = 4;
    localparam int OFFSET_W_DEF = 4;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    // Tag field: everything above index and offset. Caller truncates to TAG_W.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int index_w, input int offset_w);
        return addr >> (index_w + offset_w);
    endfunction

    // Index field: index_w bits just above the byte offset.
    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int index_w, input int offset_w);
        return (addr >> offset_w) & ((64'd1 << index_w) - 64'd1);
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side strobes, data-array controls, backing-memory handshake and counters.
// Latency: n/a (wiring only).
// Backpressure: core holds strobes/address stable while stall is high; memory completes with mem_ready.
interface cache_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
);
    logic               cpu_read;
    logic               cpu_write;
    logic [ADDR_W-1:0]  cpu_addr;
    logic               stall;
    logic               hit;
    logic               store_we;
    logic               fill_we;
    logic [INDEX_W-1:0] arr_index;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    // Controller side.
    modport slave (
        input  cpu_read, cpu_write, cpu_addr, mem_ready,
        output stall, hit, store_we, fill_we, arr_index,
               mem_req, mem_we, mem_addr, hit_cnt, miss_cnt
    );

    // Core / memory side.
    modport master (
        output cpu_read, cpu_write, cpu_addr, mem_ready,
        input  stall, hit, store_we, fill_we, arr_index,
               mem_req, mem_we, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl_tag_store.sv
// Tag/valid/dirty arrays for a direct-mapped cache; combinational read at index.
// Latency: read 0 cycles, writes take effect at the next rising edge.
// Backpressure: none; ports: index, rd_tag/rd_valid/rd_dirty, wr_en/wr_tag, dirty_set/dirty_clr.
module cache_tag_store #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    input  logic               wr_en,      // allocate: write tag, set valid, clear dirty
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               dirty_set,
    input  logic               dirty_clr
);
    localparam int LINES = 1 << INDEX_W;

    logic [TAG_W-1:0] tag_q [LINES];
    logic [TAG_W-1:0] tag_d [LINES];
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            tag_d[index]   = wr_tag;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end
        if (dirty_set) dirty_d[index] = 1'b1;
        if (dirty_clr) dirty_d[index] = 1'b0;
    end

    // Tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back data-cache controller: hit detect, write-back/refill FSM, perf counters.
// Latency: hits complete in the access cycle; misses stall 1 + writeback + allocate cycles.
// Backpressure: stall holds the core while a miss waits on mem_ready; ports via cache_ctrl_if.slave.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic          clk,
    input logic          rst_n,
    cache_ctrl_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic [TAG_W-1:0]   tag, rd_tag;
    logic [INDEX_W-1:0] index;
    logic               rd_valid, rd_dirty;
    logic               access;
    logic               tag_wr, dirty_set, dirty_clr;
    logic               hit, stall, store_we, fill_we, mem_req, mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic               hit_inc, miss_inc;

    state_e             state_q, state_d;
    logic               retry_q, retry_d;   // this IDLE cycle is the retry of a just-filled miss
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    assign tag    = TAG_W'(addr_tag(64'(bus.cpu_addr), INDEX_W, OFFSET_W));
    assign index  = INDEX_W'(addr_index(64'(bus.cpu_addr), INDEX_W, OFFSET_W));
    assign access = bus.cpu_read | bus.cpu_write;

    cache_tag_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (index),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .wr_en     (tag_wr),
        .wr_tag    (tag),
        .dirty_set (dirty_set),
        .dirty_clr (dirty_clr)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = 1'b0;
        hit       = 1'b0;
        stall     = 1'b0;
        store_we  = 1'b0;
        fill_we   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        tag_wr    = 1'b0;
        dirty_set = 1'b0;
        dirty_clr = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hit = access & rd_valid & (rd_tag == tag);
                if (hit) begin
                    // A simultaneous read+write strobe is a store.
                    store_we  = bus.cpu_write;
                    dirty_set = bus.cpu_write;
                    hit_inc   = ~retry_q;
                end else if (access) begin
                    stall    = 1'b1;
                    miss_inc = 1'b1;
                    state_d  = (rd_valid & rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {rd_tag, index, {OFFSET_W{1'b0}}};
                if (bus.mem_ready) begin
                    dirty_clr = 1'b1;
                    state_d   = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag, index, {OFFSET_W{1'b0}}};
                if (bus.mem_ready) begin
                    fill_we = 1'b1;
                    tag_wr  = 1'b1;
                    retry_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hit_cnt_d  = (hit_inc  && (hit_cnt_q  != '1)) ? hit_cnt_q  + 1'b1 : hit_cnt_q;
        miss_cnt_d = (miss_inc && (miss_cnt_q != '1)) ? miss_cnt_q + 1'b1 : miss_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Cleared valid bits would otherwise make a held strobe look like a miss during reset.
    assign bus.stall     = stall & rst_n;
    assign bus.hit       = hit;
    assign bus.store_we  = store_we;
    assign bus.fill_we   = fill_we;
    assign bus.arr_index = index;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_if #(.ADDR_W(32), .INDEX_W(4), .CNT_W(4)) bus ();

    cache_ctrl #(.ADDR_W(32), .INDEX_W(4), .OFFSET_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per-line state of a 16-line direct-mapped cache, 16-byte lines.
    bit          m_valid [16];
    bit          m_dirty [16];
    int unsigned m_tag   [16];
    int unsigned m_hits, m_misses;
    int          stall_cycles, fill_pulses;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Drives one CPU access from cycle start (posedge+1) through completion, checking every cycle.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input int wb_lat, input int al_lat);
        int          idx;
        int unsigned tg;
        bit          exp_hit, st;
        logic [31:0] line_addr, wb_addr;
        idx       = int'((addr >> 4) & 32'hF);
        tg        = addr >> 8;
        exp_hit   = m_valid[idx] && (m_tag[idx] == tg);
        st        = wr;
        line_addr = addr & ~32'hF;
        wb_addr   = (m_tag[idx] << 8) | (idx << 4);
        stall_cycles = 0;
        fill_pulses  = 0;

        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.mem_ready = 1'($urandom_range(0, 1));   // ignored in IDLE
        @(negedge clk);
        total++; if (bus.hit !== exp_hit)
            begin bad++; $display("FAIL idle_hit addr=%h got=%b exp=%b", addr, bus.hit, exp_hit); end
        total++; if (bus.arr_index !== 4'(idx))
            begin bad++; $display("FAIL arr_index addr=%h got=%0d exp=%0d", addr, bus.arr_index, idx); end
        total++; if (bus.stall !== !exp_hit)
            begin bad++; $display("FAIL idle_stall addr=%h got=%b exp=%b", addr, bus.stall, !exp_hit); end
        total++; if (bus.store_we !== (exp_hit && st))
            begin bad++; $display("FAIL idle_store_we addr=%h got=%b exp=%b", addr, bus.store_we, exp_hit && st); end
        total++; if (bus.mem_req !== 1'b0)
            begin bad++; $display("FAIL idle_mem_req addr=%h got=%b exp=0", addr, bus.mem_req); end
        if (bus.stall === 1'b1) stall_cycles++;
        @(posedge clk); #1;

        if (exp_hit) begin
            if (st) m_dirty[idx] = 1'b1;
            if (m_hits < 15) m_hits++;
        end else begin
            if (m_misses < 15) m_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int i = 1; i <= wb_lat; i++) begin
                    bus.mem_ready = (i == wb_lat);
                    @(negedge clk);
                    total++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1)
                        begin bad++; $display("FAIL wb_ctrl cyc=%0d got stall=%b req=%b we=%b exp 1/1/1", i, bus.stall, bus.mem_req, bus.mem_we); end
                    total++; if (bus.mem_addr !== wb_addr)
                        begin bad++; $display("FAIL wb_addr cyc=%0d got=%h exp=%h", i, bus.mem_addr, wb_addr); end
                    total++; if (bus.fill_we !== 1'b0 || bus.hit !== 1'b0)
                        begin bad++; $display("FAIL wb_fill_hit got fill=%b hit=%b exp 0/0", bus.fill_we, bus.hit); end
                    if (bus.stall === 1'b1) stall_cycles++;
                    if (bus.fill_we === 1'b1) fill_pulses++;
                    @(posedge clk); #1;
                end
                m_dirty[idx] = 1'b0;
            end
            for (int i = 1; i <= al_lat; i++) begin
                bus.mem_ready = (i == al_lat);
                @(negedge clk);
                total++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0)
                    begin bad++; $display("FAIL al_ctrl cyc=%0d got stall=%b req=%b we=%b exp 1/1/0", i, bus.stall, bus.mem_req, bus.mem_we); end
                total++; if (bus.mem_addr !== line_addr)
                    begin bad++; $display("FAIL al_addr cyc=%0d got=%h exp=%h", i, bus.mem_addr, line_addr); end
                total++; if (bus.fill_we !== (i == al_lat))
                    begin bad++; $display("FAIL al_fill_we cyc=%0d got=%b exp=%b", i, bus.fill_we, i == al_lat); end
                if (bus.stall === 1'b1) stall_cycles++;
                if (bus.fill_we === 1'b1) fill_pulses++;
                @(posedge clk); #1;
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
            // Retry cycle: hits, completes, not counted as a hit.
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++; if (bus.hit !== 1'b1 || bus.stall !== 1'b0 || bus.mem_req !== 1'b0)
                begin bad++; $display("FAIL retry got hit=%b stall=%b req=%b exp 1/0/0", bus.hit, bus.stall, bus.mem_req); end
            total++; if (bus.store_we !== st)
                begin bad++; $display("FAIL retry_store_we got=%b exp=%b", bus.store_we, st); end
            @(posedge clk); #1;
            if (st) m_dirty[idx] = 1'b1;
        end
        total++; if (bus.hit_cnt !== 4'(m_hits))
            begin bad++; $display("FAIL hit_cnt addr=%h got=%0d exp=%0d", addr, bus.hit_cnt, m_hits); end
        total++; if (bus.miss_cnt !== 4'(m_misses))
            begin bad++; $display("FAIL miss_cnt addr=%h got=%0d exp=%0d", addr, bus.miss_cnt, m_misses); end
    endtask

    task automatic idle_cycle();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        total++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.store_we !== 1'b0 || bus.fill_we !== 1'b0)
            begin bad++; $display("FAIL idle_outputs got stall=%b req=%b swe=%b fwe=%b exp 0", bus.stall, bus.mem_req, bus.store_we, bus.fill_we); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.cpu_read  = 1'b1;     // strobe held during reset must not raise stall
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 32'h0000_0040;
        bus.mem_ready = 1'b0;
        model_clear();
        #12;
        total++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0)
            begin bad++; $display("FAIL reset_ctrl got stall=%b req=%b we=%b exp 0/0/0", bus.stall, bus.mem_req, bus.mem_we); end
        total++; if (bus.store_we !== 1'b0 || bus.fill_we !== 1'b0)
            begin bad++; $display("FAIL reset_we got swe=%b fwe=%b exp 0/0", bus.store_we, bus.fill_we); end
        total++; if (bus.hit_cnt !== 4'd0 || bus.miss_cnt !== 4'd0)
            begin bad++; $display("FAIL reset_cnt got hit=%0d miss=%0d exp 0/0", bus.hit_cnt, bus.miss_cnt); end
        bus.cpu_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycle();
    endtask

    task automatic test_cold_read();
        do_access(1'b1, 1'b0, 32'h0000_0040, 1, 3);
        total++; if (stall_cycles != 4)
            begin bad++; $display("FAIL cold_stall_cycles got=%0d exp=4", stall_cycles); end
        total++; if (fill_pulses != 1)
            begin bad++; $display("FAIL cold_fill_pulses got=%0d exp=1", fill_pulses); end
        total++; if (bus.miss_cnt !== 4'd1 || bus.hit_cnt !== 4'd0)
            begin bad++; $display("FAIL cold_counts got hit=%0d miss=%0d exp 0/1", bus.hit_cnt, bus.miss_cnt); end
    endtask

    task automatic test_store_evict();
        do_access(1'b0, 1'b1, 32'h0000_0044, 1, 1);
        total++; if (bus.hit_cnt !== 4'd1)
            begin bad++; $display("FAIL store_hit_cnt got=%0d exp=1", bus.hit_cnt); end
        do_access(1'b1, 1'b0, 32'h0000_0140, 2, 2);
        total++; if (stall_cycles != 5)
            begin bad++; $display("FAIL dirty_evict_stall got=%0d exp=5", stall_cycles); end
    endtask

    task automatic test_clean_evict();
        do_access(1'b1, 1'b0, 32'h0000_0048, 1, 2);
        total++; if (stall_cycles != 3)
            begin bad++; $display("FAIL clean_evict_stall got=%0d exp=3", stall_cycles); end
        do_access(1'b1, 1'b0, 32'h0000_014C, 1, 1);   // ready in first ALLOCATE cycle
        total++; if (stall_cycles != 2)
            begin bad++; $display("FAIL first_cycle_ready_stall got=%0d exp=2", stall_cycles); end
    endtask

    task automatic test_both_strobes();
        do_access(1'b1, 1'b1, 32'h0000_0140, 1, 1);
        // Dirty line must now be written back before the refill.
        do_access(1'b1, 1'b0, 32'h0000_0040, 1, 1);
        total++; if (stall_cycles != 3)
            begin bad++; $display("FAIL both_strobes_dirty got_stall=%0d exp=3", stall_cycles); end
    endtask

    task automatic test_reset_mid_alloc();
        idle_cycle();
        bus.cpu_read  = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 32'h0000_0280;   // index 8, never touched: clean miss
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (bus.mem_req !== 1'b1)
            begin bad++; $display("FAIL mid_alloc_req got=%b exp=1", bus.mem_req); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0)
            begin bad++; $display("FAIL reset_abort got req=%b stall=%b exp 0/0", bus.mem_req, bus.stall); end
        total++; if (bus.hit_cnt !== 4'd0 || bus.miss_cnt !== 4'd0)
            begin bad++; $display("FAIL reset_abort_cnt got hit=%0d miss=%0d exp 0/0", bus.hit_cnt, bus.miss_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        do_access(1'b1, 1'b0, 32'h0000_0280, 1, 2);
        do_access(1'b1, 1'b0, 32'h0000_0044, 1, 1);   // was valid before reset; must miss again
        total++; if (bus.miss_cnt !== 4'd2)
            begin bad++; $display("FAIL post_reset_miss got=%0d exp=2", bus.miss_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int op;
            a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            op = $urandom_range(0, 2);
            do_access(op != 1, op != 0, a, $urandom_range(1, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h0000_0040, 1, 1);
        for (int n = 0; n < 20; n++) do_access(1'b1, 1'b0, 32'h0000_0040 + 32'(n % 16), 1, 1);
        total++; if (bus.hit_cnt !== 4'hF)
            begin bad++; $display("FAIL hit_cnt_sat got=%0d exp=15", bus.hit_cnt); end
        total++; if (bus.miss_cnt !== 4'd1)
            begin bad++; $display("FAIL sat_miss_cnt got=%0d exp=1", bus.miss_cnt); end
    endtask

    initial begin
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_cold_read();
        test_store_evict();
        test_clean_evict();
        test_both_strobes();
        test_reset_mid_alloc();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
